store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter XLEN, default 32, data-memory address/data width.
REQ-002 Parameter DEPTH, default 4, max expected-store entries (power of 2, >=2).
REQ-003 Parameter TIMEOUT, default 1000, max RUN cycles before timeout (>=1).
REQ-004 Parameter IGN_BASE, default 96, base byte address of the ignore window.
REQ-005 Parameter IGN_SIZE, default 4, ignore-window size in bytes (0 disables the window).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 MemWrite  in  1  CPU data-memory write strobe.
REQ-009 DataAdr  in  XLEN  CPU data-memory address.
REQ-010 WriteData  in  XLEN  CPU store data.
REQ-011 load_valid  in  1  appends (load_adr, load_data) to the expected table.
REQ-012 load_adr / load_data  in  XLEN each  expected store address / data.
REQ-013 start  in  1  single-cycle pulse; begins checking.
REQ-014 clear  in  1  single-cycle pulse; returns to IDLE and empties the table.
REQ-015 load_full  out  1  table holds DEPTH entries.
REQ-016 status  out  3  one-hot {timeout, fail, pass}; all 0 in IDLE/RUN.
REQ-017 hit  out  1  one-cycle pulse on each matched entry.
REQ-018 hit_idx  out  $clog2(DEPTH)  index of matched entry, valid with hit.
REQ-019 fail_adr / fail_data  out  XLEN each  first offending store, captured on FAIL.
REQ-020 cycles  out  $clog2(TIMEOUT+1)  RUN cycle count, frozen after terminal state.

Function
REQ-021 FSM states IDLE, RUN, PASS, FAIL, TIMEOUT; PASS/FAIL/TIMEOUT are terminal until clear or reset.
REQ-022 IDLE: load_valid with count<DEPTH writes entry[count] and increments count; load_valid at full is ignored.
REQ-023 IDLE: start with count>0 -> RUN next cycle, ptr=0, cycles=0; start with count=0 is ignored.
REQ-024 Same-cycle start and load_valid in IDLE: start is accepted with the pre-load count, and the load is discarded.
REQ-025 load_valid and start outside IDLE are ignored; MemWrite outside RUN is ignored.
REQ-026 RUN: cycles increments every cycle, saturating at TIMEOUT.
REQ-027 RUN, MemWrite, DataAdr==entry[ptr].adr and WriteData==entry[ptr].data: hit=1 and hit_idx=ptr on the next cycle; ptr increments.
REQ-028 A match on entry count-1 goes to PASS (status=001) on the next cycle.
REQ-029 RUN, MemWrite, no match, DataAdr in [IGN_BASE, IGN_BASE+IGN_SIZE): store is ignored, with no state change.
REQ-030 RUN, MemWrite, no match, outside the window: FAIL (status=010), and fail_adr/fail_data latch DataAdr/WriteData.
REQ-031 Match test takes priority over the ignore test.
REQ-032 cycles reaching TIMEOUT with no terminal event -> TIMEOUT (status=100); a MemWrite in that same cycle is evaluated first, and its result wins.
REQ-033 clear in any state -> IDLE, count=0, ptr=0, status=0; clear wins over start/load in the same cycle.
REQ-034 Full-width equality compares only; no masking and no byte enables.

Reset
REQ-035 reset forces IDLE, count=0, ptr=0, cycles=0, status=0, hit=0, hit_idx=0, fail_adr=0, fail_data=0, load_full=0.
REQ-036 reset mid-RUN discards all progress and the table; reset has priority over every input.

Structure
REQ-037 Shared package store_checker_pkg holds the state enum, the status bit positions, and the entry struct {adr, data} sized by XLEN.
REQ-038 The table is a sub-module expect_table (DEPTH x 2*XLEN register file, one write port, one async read port at ptr).

Verification
REQ-039 Load (96,7),(32,25); start; stores (96,3),(96,7),(32,25) -> (96,3) ignored, hit idx0 then idx1, status=001.
REQ-040 Same table; store (40,25) -> status=010, fail_adr=40, fail_data=25, no hit.
REQ-041 TIMEOUT=10, one entry; no MemWrite after start -> status=100 exactly 10 cycles after RUN entry, cycles=10.
REQ-042 DEPTH=4: five loads -> load_full=1 after the 4th, and the 5th is dropped; start with count=0 -> remains IDLE.
REQ-043 reset asserted mid-RUN after one hit -> all outputs 0; a new load/start sequence then passes.
REQ-044 Same-cycle start+load with count=1 -> RUN with one entry; the match on it gives PASS.

Source files
------------

// File: rtl/store_checker_pkg.sv
// store_checker_pkg: types and constants shared by the store checker and its
// expected-store table.
//   state_t   - checker FSM states
//   STATUS_*  - bit positions inside the one-hot status output
//   entry_t   - one expected store {adr, data}, ENTRY_XLEN bits per field
package store_checker_pkg;

    // Field width of a table entry; the top-level XLEN must equal this.
    localparam int ENTRY_XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam int STATUS_PASS    = 0;
    localparam int STATUS_FAIL    = 1;
    localparam int STATUS_TIMEOUT = 2;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] adr;
        logic [ENTRY_XLEN-1:0] data;
    } entry_t;

endpackage

// File: rtl/store_checker_expect_table.sv
// expect_table: DEPTH-entry register file of expected stores.
// One synchronous write port, one asynchronous read port.
//   clk       in   clock
//   wr_en     in   write strobe
//   wr_idx    in   write index
//   wr_entry  in   entry to write
//   rd_idx    in   read index
//   rd_entry  out  entry at rd_idx (combinational)
module expect_table
    import store_checker_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  entry_t        wr_entry,
    input  logic [AW-1:0] rd_idx,
    output entry_t        rd_entry
);

    entry_t mem [DEPTH];

    // NOTE: the storage array has no reset; the checker's entry count decides
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/store_checker.sv
// store_checker: loads a table of expected (address, data) stores, then
// watches the CPU data-memory write port and checks that stores arrive in
// table order. Stores into the ignore window that do not match are skipped.
// Ends in PASS (all entries matched), FAIL (unexpected store) or TIMEOUT.
//   clk, reset            clock, synchronous active-high reset
//   MemWrite/DataAdr/WriteData  CPU store port being checked
//   load_valid/load_adr/load_data  append an expected store (IDLE only)
//   start, clear          begin checking / return to IDLE and empty table
//   load_full             table holds DEPTH entries
//   status                one-hot {timeout, fail, pass}
//   hit, hit_idx          one-cycle pulse and index for each matched entry
//   fail_adr, fail_data   first offending store
//   cycles                RUN cycle count, frozen once terminal
module store_checker
    import store_checker_pkg::*;
#(
    parameter int XLEN     = ENTRY_XLEN,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 1000,
    parameter int IGN_BASE = 96,
    parameter int IGN_SIZE = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int CYC_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [XLEN-1:0]  DataAdr,
    input  logic [XLEN-1:0]  WriteData,
    input  logic             load_valid,
    input  logic [XLEN-1:0]  load_adr,
    input  logic [XLEN-1:0]  load_data,
    input  logic             start,
    input  logic             clear,
    output logic             load_full,
    output logic [2:0]       status,
    output logic             hit,
    output logic [PTR_W-1:0] hit_idx,
    output logic [XLEN-1:0]  fail_adr,
    output logic [XLEN-1:0]  fail_data,
    output logic [CYC_W-1:0] cycles
);

    // One extra bit so IGN_BASE+IGN_SIZE cannot wrap; IGN_SIZE=0 gives an
    // empty window because the bounds coincide.
    localparam logic [XLEN:0] IGN_LO = (XLEN + 1)'(IGN_BASE);
    localparam logic [XLEN:0] IGN_HI = (XLEN + 1)'(IGN_BASE + IGN_SIZE);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] ptr;
    entry_t           wr_entry;
    entry_t           rd_entry;

    logic start_ok;
    logic tbl_we;
    logic entry_match;
    logic last_entry;
    logic in_ign;
    logic run_hit;
    logic run_fail;
    logic cyc_expire;

    assign load_full = (count == CNT_W'(DEPTH));

    // A start that is accepted swallows a same-cycle load.
    assign start_ok = (state == S_IDLE) && start && (count != '0);
    assign tbl_we   = (state == S_IDLE) && load_valid && !load_full
                      && !start_ok && !clear;
    assign wr_entry = '{adr: load_adr, data: load_data};

    expect_table #(
        .DEPTH    (DEPTH)
    ) u_table (
        .clk      (clk),
        .wr_en    (tbl_we),
        .wr_idx   (count[PTR_W-1:0]),
        .wr_entry (wr_entry),
        .rd_idx   (ptr),
        .rd_entry (rd_entry)
    );

    assign entry_match = (DataAdr == rd_entry.adr) && (WriteData == rd_entry.data);
    assign last_entry  = ((CNT_W'(ptr) + 1'b1) == count);
    assign in_ign      = ({1'b0, DataAdr} >= IGN_LO) && ({1'b0, DataAdr} < IGN_HI);
    // Match is tested before the ignore window.
    assign run_hit     = (state == S_RUN) && MemWrite && entry_match;
    assign run_fail    = (state == S_RUN) && MemWrite && !entry_match && !in_ign;
    assign cyc_expire  = (cycles == CYC_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned,
        // which would infer a latch.
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                // The store outcome is resolved before the timeout so a
                // terminal store in the expiring cycle wins.
                if (run_hit && last_entry) begin
                    next_state = S_PASS;
                end else if (run_fail) begin
                    next_state = S_FAIL;
                end else if (cyc_expire) begin
                    next_state = S_TIMEOUT;
                end
            end
            default: ;
        endcase
        if (clear) begin
            next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            ptr       <= '0;
            cycles    <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else begin
            hit <= 1'b0;
            if (clear) begin
                count <= '0;
                ptr   <= '0;
            end else if (state == S_IDLE) begin
                if (start_ok) begin
                    ptr    <= '0;
                    cycles <= '0;
                end else if (tbl_we) begin
                    count <= count + 1'b1;
                end
            end else if (state == S_RUN) begin
                if (cycles != CYC_W'(TIMEOUT)) begin
                    cycles <= cycles + 1'b1;
                end
                if (run_hit) begin
                    hit     <= 1'b1;
                    hit_idx <= ptr;
                    ptr     <= ptr + 1'b1;
                end else if (run_fail) begin
                    fail_adr  <= DataAdr;
                    fail_data <= WriteData;
                end
            end
        end
    end

    always_comb begin
        status                 = '0;
        status[STATUS_PASS]    = (state == S_PASS);
        status[STATUS_FAIL]    = (state == S_FAIL);
        status[STATUS_TIMEOUT] = (state == S_TIMEOUT);
    end

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker (DEPTH=4, TIMEOUT=10, window [96,100)).
// Expected hit indices are queued as matching stores are driven; a monitor
// collects observed hits and each scenario compares the two queues.
module tb_store_checker;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            MemWrite;
    logic [XLEN-1:0] DataAdr;
    logic [XLEN-1:0] WriteData;
    logic            load_valid;
    logic [XLEN-1:0] load_adr;
    logic [XLEN-1:0] load_data;
    logic            start;
    logic            clear;
    logic            load_full;
    logic [2:0]      status;
    logic            hit;
    logic [1:0]      hit_idx;
    logic [XLEN-1:0] fail_adr;
    logic [XLEN-1:0] fail_data;
    logic [3:0]      cycles;

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int got_q[$];

    store_checker #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .IGN_BASE  (96),
        .IGN_SIZE  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .load_valid(load_valid),
        .load_adr  (load_adr),
        .load_data (load_data),
        .start     (start),
        .clear     (clear),
        .load_full (load_full),
        .status    (status),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .fail_adr  (fail_adr),
        .fail_data (fail_data),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hit === 1'b1) got_q.push_back(int'(hit_idx));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int adr, input int data);
        load_valid = 1'b1;
        load_adr   = adr;
        load_data  = data;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic do_store(input int adr, input int data, input bit expect_hit, input int idx);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        if (expect_hit) exp_q.push_back(idx);
        cyc();
        MemWrite = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; MemWrite = 0; DataAdr = 0; WriteData = 0;
        load_valid = 0; load_adr = 0; load_data = 0; start = 0; clear = 0;
        cyc(); cyc();
        reset = 1'b0;
        checks++; if (status !== 3'b000) begin failures++; $display("FAIL reset_status got=%b want=000", status); end
        checks++; if (hit !== 1'b0 || hit_idx !== 2'd0) begin failures++; $display("FAIL reset_hit got=%b/%0d want=0/0", hit, hit_idx); end
        checks++; if (fail_adr !== 0 || fail_data !== 0) begin failures++; $display("FAIL reset_fail_regs got=%0d/%0d want=0/0", fail_adr, fail_data); end
        checks++; if (load_full !== 1'b0 || cycles !== 4'd0) begin failures++; $display("FAIL reset_full_cycles got=%b/%0d want=0/0", load_full, cycles); end
    endtask

    task automatic test_pass();
        pulse_clear();
        do_load(96, 7);
        do_load(32, 25);
        pulse_start();
        do_store(96, 3, 0, 0);
        checks++; if (status !== 3'b000) begin failures++; $display("FAIL pass_ignored_store status got=%b want=000", status); end
        do_store(96, 7, 1, 0);
        do_store(32, 25, 1, 1);
        checks++; if (status !== 3'b001) begin failures++; $display("FAIL pass_status got=%b want=001", status); end
        checks++; if (cycles !== 4'd3) begin failures++; $display("FAIL pass_cycles got=%0d want=3", cycles); end
        cyc();
        checks++; if (hit !== 1'b0 || status !== 3'b001) begin failures++; $display("FAIL pass_terminal hit/status got=%b/%b want=0/001", hit, status); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL pass_hit_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            int e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL pass_hit_idx got=%0d want=%0d", g, e); end
        end
    endtask

    task automatic test_fail();
        pulse_clear();
        checks++; if (status !== 3'b000) begin failures++; $display("FAIL clear_status got=%b want=000", status); end
        do_load(96, 7);
        do_load(32, 25);
        pulse_start();
        do_store(40, 25, 0, 0);
        checks++; if (status !== 3'b010) begin failures++; $display("FAIL fail_status got=%b want=010", status); end
        checks++; if (fail_adr !== 40 || fail_data !== 25) begin failures++; $display("FAIL fail_capture got=%0d/%0d want=40/25", fail_adr, fail_data); end
        do_store(96, 7, 0, 0);
        checks++; if (status !== 3'b010 || got_q.size() != 0) begin failures++; $display("FAIL fail_no_hit status=%b hits=%0d want=010/0", status, got_q.size()); end
    endtask

    task automatic test_timeout();
        pulse_clear();
        do_load(200, 1);
        pulse_start();
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc();
            if (i == TIMEOUT - 1) begin
                checks++; if (status !== 3'b000) begin failures++; $display("FAIL timeout_early got=%b want=000 at cycle %0d", status, i); end
            end
        end
        checks++; if (status !== 3'b100) begin failures++; $display("FAIL timeout_status got=%b want=100", status); end
        checks++; if (cycles !== 4'(TIMEOUT)) begin failures++; $display("FAIL timeout_cycles got=%0d want=%0d", cycles, TIMEOUT); end
        cyc(); cyc();
        checks++; if (cycles !== 4'(TIMEOUT) || status !== 3'b100) begin failures++; $display("FAIL timeout_frozen got=%0d/%b want=%0d/100", cycles, status, TIMEOUT); end
    endtask

    task automatic test_full();
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            do_load(16 + 4 * i, 100 + i);
            if (i == 2) begin
                checks++; if (load_full !== 1'b0) begin failures++; $display("FAIL full_after3 got=%b want=0", load_full); end
            end
            if (i >= 3) begin
                checks++; if (load_full !== 1'b1) begin failures++; $display("FAIL full_after%0d got=%b want=1", i + 1, load_full); end
            end
        end
        pulse_start();
        for (int i = 0; i < 4; i++) do_store(16 + 4 * i, 100 + i, 1, i);
        checks++; if (status !== 3'b001) begin failures++; $display("FAIL full_pass got=%b want=001", status); end
        cyc();
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL full_hit_count got=%0d want=4", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            int e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL full_hit_idx got=%0d want=%0d", g, e); end
        end
        pulse_clear();
        pulse_start();
        do_store(40, 25, 0, 0);
        checks++; if (status !== 3'b000 || hit !== 1'b0) begin failures++; $display("FAIL empty_start status/hit got=%b/%b want=000/0", status, hit); end
    endtask

    task automatic test_reset_mid_run();
        pulse_clear();
        do_load(96, 7);
        do_load(32, 25);
        pulse_start();
        do_store(96, 7, 1, 0);
        checks++; if (hit !== 1'b1 || hit_idx !== 2'd0) begin failures++; $display("FAIL midrun_hit got=%b/%0d want=1/0", hit, hit_idx); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (status !== 0 || hit !== 0 || hit_idx !== 0 || load_full !== 0 || cycles !== 0) begin
            failures++; $display("FAIL midrun_reset_outputs status=%b hit=%b idx=%0d full=%b cycles=%0d want all 0", status, hit, hit_idx, load_full, cycles);
        end
        checks++; if (fail_adr !== 0 || fail_data !== 0) begin failures++; $display("FAIL midrun_reset_fail_regs got=%0d/%0d want=0/0", fail_adr, fail_data); end
        got_q.delete(); exp_q.delete();
        do_load(8, 9);
        pulse_start();
        do_store(8, 9, 1, 0);
        checks++; if (status !== 3'b001) begin failures++; $display("FAIL after_reset_pass got=%b want=001", status); end
        cyc();
        checks++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin failures++; $display("FAIL after_reset_hits got=%0d entries want=1 idx0", got_q.size()); end
    endtask

    task automatic test_same_cycle_start_load();
        pulse_clear();
        do_load(50, 60);
        start      = 1'b1;
        load_valid = 1'b1;
        load_adr   = 70;
        load_data  = 80;
        cyc();
        start      = 1'b0;
        load_valid = 1'b0;
        checks++; if (status !== 3'b000 || load_full !== 1'b0) begin failures++; $display("FAIL same_cycle_run status/full got=%b/%b want=000/0", status, load_full); end
        do_store(50, 60, 1, 0);
        checks++; if (status !== 3'b001) begin failures++; $display("FAIL same_cycle_pass got=%b want=001", status); end
        cyc();
        checks++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin failures++; $display("FAIL same_cycle_hits got=%0d entries want=1 idx0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_full();
        test_reset_mid_run();
        test_same_cycle_start_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
